// File: rtl/pkt_fifo_pkg.sv
// Shared definitions for the store-and-forward packet FIFO: default widths,
// beat layout {last,data} and the read-side mode encoding.
package pkt_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_DEPTH  = 16;

    // STORE: only complete packets are visible; RELEASE: an oversize packet drains cut-through
    typedef enum logic {
        MODE_STORE   = 1'b0,
        MODE_RELEASE = 1'b1
    } mode_e;

    function automatic int unsigned beat_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Beat storage for pkt_fifo: DEPTH x WIDTH, one synchronous write port and
// one asynchronous read port.
module pkt_fifo_mem
    import pkt_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = beat_w(DEFAULT_DATA_W),
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO: presents only complete packets downstream,
// with a cut-through escape when a single packet overfills the storage.
module pkt_fifo
    import pkt_fifo_pkg::*;
#(
    parameter  int unsigned DATA_W = DEFAULT_DATA_W,
    parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic              m_last,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [AW:0]       level,
    output logic [AW:0]       pkt_count,
    output logic              oversize
);

    localparam int unsigned BEAT_W = beat_w(DATA_W);
    localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       pkt_count_q, pkt_count_d;
    logic              oversize_q, oversize_d;
    mode_e             mode_q, mode_d;

    logic              empty;
    logic              full;
    logic              wr_fire;
    logic              rd_fire;
    logic [BEAT_W-1:0] rd_beat;

    pkt_fifo_mem #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data ({s_last, s_data}),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_beat)
    );

    // Handshake outputs depend only on registered state (no full-FIFO pass-through)
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        s_ready = !full && !rst;
        m_valid = !empty && ((pkt_count_q != '0) || (mode_q == MODE_RELEASE)) && !rst;
        m_last  = rd_beat[DATA_W];
        m_data  = rd_beat[DATA_W-1:0];
        wr_fire = s_valid && s_ready;
        rd_fire = m_valid && m_ready;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_count_d = pkt_count_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        case ({wr_fire && s_last, rd_fire && m_last})
            2'b10:   pkt_count_d = pkt_count_q + ONE;
            2'b01:   pkt_count_d = pkt_count_q - ONE;
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    // Full with no complete packet means one packet exceeds DEPTH: drain it cut-through
    always_comb begin
        mode_d     = mode_q;
        oversize_d = oversize_q;
        case (mode_q)
            MODE_STORE: begin
                if (full && (pkt_count_q == '0)) begin
                    mode_d     = MODE_RELEASE;
                    oversize_d = 1'b1;
                end
            end
            MODE_RELEASE: begin
                if (rd_fire && m_last) begin
                    mode_d = MODE_STORE;
                end
            end
            default: mode_d = MODE_STORE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            oversize_q  <= 1'b0;
            mode_q      <= MODE_STORE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            oversize_q  <= oversize_d;
            mode_q      <= mode_d;
        end
    end

    assign level     = wr_ptr_q - rd_ptr_q;
    assign pkt_count = pkt_count_q;
    assign oversize  = oversize_q;

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed self-checking bench for pkt_fifo (DATA_W=8, DEPTH=16).
module tb_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_last;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic       m_last;
    logic [7:0] m_data;
    logic       m_ready;
    logic [4:0] level;
    logic [4:0] pkt_count;
    logic       oversize;

    int total = 0;
    int bad   = 0;

    pkt_fifo #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .level     (level),
        .pkt_count (pkt_count),
        .oversize  (oversize)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs a source stream and a m_ready=1 sink together, checking every beat read.
    task automatic run_flow(input logic [7:0] sb, input int sn, input logic [7:0] eb,
                            input int en, input bit all_last, input string tag);
        int si  = 0;
        int ei  = 0;
        int cyc = 0;
        bit wr;
        logic [7:0] e;
        while ((si < sn || ei < en) && cyc < 200) begin
            s_valid = (si < sn);
            s_data  = sb + 8'(si);
            s_last  = all_last || (si == sn - 1);
            if (m_valid) begin
                e = eb + 8'(ei);
                chk({tag, "_no_extra"}, 32'(ei < en), 32'd1);
                chk({tag, "_data"}, 32'(m_data), 32'(e));
                chk({tag, "_last"}, 32'(m_last), 32'(all_last || (ei == en - 1)));
                ei++;
            end
            wr = s_valid && s_ready;
            tick();
            if (wr) si++;
            cyc++;
        end
        s_valid = 1'b0;
        chk({tag, "_beats_out"}, 32'(ei), 32'(en));
        chk({tag, "_beats_in"}, 32'(si), 32'(sn));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with upstream asserting valid
        rst = 1'b1; s_valid = 1'b1; s_last = 1'b0; s_data = 8'hEE; m_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_s_ready", 32'(s_ready), 0);
            chk("rst_m_valid", 32'(m_valid), 0);
            chk("rst_level", 32'(level), 0);
            chk("rst_pkt_count", 32'(pkt_count), 0);
            chk("rst_oversize", 32'(oversize), 0);
        end
        rst = 1'b0; s_valid = 1'b0;
        tick();
        chk("idle_s_ready", 32'(s_ready), 1);
        chk("idle_level", 32'(level), 0);

        // 2: store-and-forward of a 4-beat packet
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 8'h10 + 8'(i); s_last = (i == 3);
            chk("saf_hold_m_valid", 32'(m_valid), 0);
            chk("saf_s_ready", 32'(s_ready), 1);
            tick();
        end
        s_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("saf_m_valid", 32'(m_valid), 1);
            chk("saf_m_data", 32'(m_data), 32'h10 + 32'(j));
            chk("saf_m_last", 32'(m_last), 32'(j == 3));
            tick();
        end
        chk("saf_done_m_valid", 32'(m_valid), 0);
        chk("saf_done_level", 32'(level), 0);
        chk("saf_done_pkt_count", 32'(pkt_count), 0);

        // 3: backpressure until full with 1-beat packets
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = 8'(i); s_last = 1'b1;
            chk("bp_s_ready", 32'(s_ready), 1);
            tick();
        end
        s_data = 8'h10;
        chk("bp_full_s_ready", 32'(s_ready), 0);
        chk("bp_full_level", 32'(level), 16);
        chk("bp_full_pkt_count", 32'(pkt_count), 16);
        chk("bp_full_m_valid", 32'(m_valid), 1);
        chk("bp_full_oversize", 32'(oversize), 0);
        tick();
        chk("bp_nopass_level", 32'(level), 16);
        m_ready = 1'b1;
        run_flow(8'h10, 2, 8'h00, 18, 1'b1, "bp");
        chk("bp_empty_level", 32'(level), 0);
        chk("bp_empty_m_valid", 32'(m_valid), 0);

        // 4: simultaneous read and write across pointer wrap, 2-beat packets
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'h40; s_last = 1'b0;
        tick();
        s_data = 8'h41; s_last = 1'b1;
        tick();
        chk("sim_pre_level", 32'(level), 2);
        chk("sim_pre_pkt_count", 32'(pkt_count), 1);
        m_ready = 1'b1;
        for (int k = 0; k < 48; k++) begin
            s_valid = 1'b1; s_data = 8'h42 + 8'(k); s_last = k[0];
            chk("sim_s_ready", 32'(s_ready), 1);
            chk("sim_m_valid", 32'(m_valid), 1);
            chk("sim_m_data", 32'(m_data), 32'h40 + 32'(k));
            chk("sim_m_last", 32'(m_last), 32'(k[0]));
            chk("sim_level", 32'(level), 2);
            chk("sim_pkt_count", 32'(pkt_count), 1);
            tick();
        end
        s_valid = 1'b0;
        for (int k = 48; k < 50; k++) begin
            chk("sim_tail_m_data", 32'(m_data), 32'h40 + 32'(k));
            chk("sim_tail_m_last", 32'(m_last), 32'(k[0]));
            tick();
        end
        chk("sim_done_level", 32'(level), 0);
        chk("sim_done_m_valid", 32'(m_valid), 0);

        // 5: oversize 20-beat packet
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = 8'h20 + 8'(i); s_last = 1'b0;
            chk("ovr_s_ready", 32'(s_ready), 1);
            tick();
        end
        s_data = 8'h30;
        chk("ovr_full_s_ready", 32'(s_ready), 0);
        chk("ovr_full_m_valid", 32'(m_valid), 0);
        chk("ovr_full_pkt_count", 32'(pkt_count), 0);
        chk("ovr_full_level", 32'(level), 16);
        tick();
        chk("ovr_oversize", 32'(oversize), 1);
        chk("ovr_m_valid", 32'(m_valid), 1);
        chk("ovr_m_data", 32'(m_data), 32'h20);
        m_ready = 1'b1;
        run_flow(8'h30, 4, 8'h20, 20, 1'b0, "ovr");
        chk("ovr_done_level", 32'(level), 0);
        chk("ovr_sticky", 32'(oversize), 1);

        // 6: reset mid-packet (also shows release cleared: partial beats stay hidden)
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'h55 + 8'(i); s_last = 1'b0;
            tick();
            chk("mid_m_valid", 32'(m_valid), 0);
        end
        chk("mid_level", 32'(level), 3);
        s_valid = 1'b0; rst = 1'b1;
        #1;
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_after_level", 32'(level), 0);
        chk("mid_after_m_valid", 32'(m_valid), 0);
        chk("mid_after_oversize", 32'(oversize), 0);
        s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("aa_m_valid", 32'(m_valid), 1);
        chk("aa_m_data", 32'(m_data), 32'hAA);
        chk("aa_m_last", 32'(m_last), 1);
        chk("aa_pkt_count", 32'(pkt_count), 1);
        tick();
        chk("aa_done_m_valid", 32'(m_valid), 0);
        chk("aa_done_level", 32'(level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
